ds_capture_buffer: RTL and testbench

//  Triggered capture RAM directly downstream of the decimation chain (CIC -> comp -> HB).

---
 rtl/ds_capture_buffer_if.sv | 34 +++
 rtl/ds_capture_buffer.sv | 145 ++++++++++++++
 tb/tb_ds_capture_buffer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds_capture_buffer_if.sv
// Bus bundle for ds_capture_buffer: sample stream in, trigger/config controls, CPU read port and status out.
// The sample stream is strobe-only: sample_ce marks a valid sample_in for exactly one cycle, no backpressure.
interface ds_capture_buffer_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic [DW-1:0] sample_in;
  logic          sample_ce;
  logic          arm;
  logic          sw_trig;
  logic          trig_lvl_en;
  logic [DW-1:0] trig_lvl;
  logic [AW:0]   capture_len;
  logic [AW-1:0] pretrig_len;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trig_addr;
  logic [1:0]    dbg_state;

  modport master (
    output sample_in, sample_ce, arm, sw_trig, trig_lvl_en, trig_lvl,
           capture_len, pretrig_len, rd_addr,
    input  rd_data, busy, done, start_addr, trig_addr, dbg_state
  );

  modport slave (
    input  sample_in, sample_ce, arm, sw_trig, trig_lvl_en, trig_lvl,
           capture_len, pretrig_len, rd_addr,
    output rd_data, busy, done, start_addr, trig_addr, dbg_state
  );
endinterface

// File: rtl/ds_capture_buffer.sv
// Triggered capture RAM for the decimated sample stream, read back by the CPU.
// Optional pre-trigger history is enabled by defining DS_CAPTURE_PRETRIG_EN.
module ds_capture_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic            clk,
  input logic            reset,
  ds_capture_buffer_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic          done_q;
  logic [AW-1:0] start_addr_q;
  logic [AW-1:0] trig_addr_q;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   remain;
  logic [AW-1:0] since_arm;
  logic          prev_valid;
  logic [DW-1:0] prev_sample;
  logic          pend_trig;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   len;
  logic [AW:0]   len_m1;
  logic [AW:0]   pre_len;
  logic [AW:0]   post_len;
  logic [AW-1:0] pre_avail;
  logic          pre_wr;
  logic          lvl_hit;
  logic          trig_hit;
  logic          wr_en;

  assign len    = (bus.capture_len == '0 || bus.capture_len > DEPTH_L) ? DEPTH_L : bus.capture_len;
  assign len_m1 = len - 1'b1;

`ifdef DS_CAPTURE_PRETRIG_EN
  // History kept before the trigger is bounded by what has actually arrived since arm.
  assign pre_len   = ({1'b0, bus.pretrig_len} < len_m1) ? {1'b0, bus.pretrig_len} : len_m1;
  assign pre_avail = ({1'b0, since_arm} < pre_len) ? since_arm : pre_len[AW-1:0];
  assign post_len  = len_m1 - pre_len;
  assign pre_wr    = 1'b1;
`else
  logic unused_ok;
  assign unused_ok = ^{bus.pretrig_len, since_arm};
  assign pre_len   = '0;
  assign pre_avail = '0;
  assign post_len  = len_m1;
  assign pre_wr    = 1'b0;
`endif

  assign lvl_hit  = bus.trig_lvl_en && prev_valid &&
                    ($signed(prev_sample) < $signed(bus.trig_lvl)) &&
                    ($signed(bus.sample_in) >= $signed(bus.trig_lvl));
  assign trig_hit = bus.sample_ce && (bus.sw_trig || pend_trig || lvl_hit);
  assign wr_en    = !bus.arm && bus.sample_ce &&
                    (state == S_CAPTURE || (state == S_ARMED && (trig_hit || pre_wr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      done_q       <= 1'b0;
      start_addr_q <= '0;
      trig_addr_q  <= '0;
      wr_ptr       <= '0;
      remain       <= '0;
      since_arm    <= '0;
      prev_valid   <= 1'b0;
      prev_sample  <= '0;
      pend_trig    <= 1'b0;
    end else if (bus.arm) begin
      // Arm overrides any trigger arriving in the same cycle.
      state      <= S_ARMED;
      done_q     <= 1'b0;
      wr_ptr     <= '0;
      remain     <= '0;
      since_arm  <= '0;
      prev_valid <= 1'b0;
      pend_trig  <= 1'b0;
    end else begin
      if (bus.sample_ce) begin
        prev_sample <= bus.sample_in;
        prev_valid  <= 1'b1;
      end
      case (state)
        S_ARMED: begin
          if (trig_hit) begin
            trig_addr_q  <= wr_ptr;
            start_addr_q <= wr_ptr - pre_avail;
            pend_trig    <= 1'b0;
            wr_ptr       <= wr_ptr + 1'b1;
            if (post_len == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= S_CAPTURE;
              remain <= post_len;
            end
          end else begin
            if (bus.sw_trig) pend_trig <= 1'b1;
            if (bus.sample_ce && pre_wr) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (since_arm != '1) since_arm <= since_arm + 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (bus.sample_ce) begin
            wr_ptr <= wr_ptr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == (AW+1)'(1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.sample_in;
  end

  // Read-first: a same-address write on this edge is not visible until the next read.
  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem[bus.rd_addr];
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = (state == S_ARMED) || (state == S_CAPTURE);
  assign bus.done       = done_q;
  assign bus.start_addr = start_addr_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_ds_capture_buffer.sv
// Self-checking bench for ds_capture_buffer; pre-trigger scenario runs when DS_CAPTURE_PRETRIG_EN is defined.
module tb_ds_capture_buffer;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
`ifdef DS_CAPTURE_PRETRIG_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ds_capture_buffer_if #(.DW(DW), .AW(AW)) bus ();
  ds_capture_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pat[DEPTH];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] v, input bit trig = 1'b0);
    bus.sample_in = v;
    bus.sample_ce = 1'b1;
    bus.sw_trig   = trig;
    tick();
    bus.sample_ce = 1'b0;
    bus.sw_trig   = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic rd_mem(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.rd_addr = a;
    tick();
    d = bus.rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", bus.rd_data); end
    checks++; if (bus.dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
    reset = 1'b0;
    tick();
    strobe(16'h0abc, 1'b1);
    checks++; if (bus.dbg_state !== S_IDLE) begin failures++; $display("FAIL idle_ignores_trig got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
  endtask

  task automatic test_sw_trig();
    logic [DW-1:0] d;
    bus.capture_len = 11'd8;
    pulse_arm();
    bus.sw_trig = 1'b1;
    tick();
    bus.sw_trig = 1'b0;
    checks++; if (bus.dbg_state !== S_ARMED) begin failures++; $display("FAIL swtrig_pending_state got=%0d exp=%0d", bus.dbg_state, S_ARMED); end
    for (int i = 0; i < 10; i++) begin
      strobe(DW'(100 + i));
      if (i < 8) exp_q.push_back(DW'(100 + i));
      if (i == 6) begin
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL swtrig_done_early got=%0b exp=0", bus.done); end
      end
      if (i == 7) begin
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL swtrig_done got=%0b exp=1", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL swtrig_busy got=%0b exp=0", bus.busy); end
      end
      repeat (3) tick();
    end
    checks++; if (bus.trig_addr !== '0) begin failures++; $display("FAIL swtrig_trig_addr got=%0d exp=0", bus.trig_addr); end
    checks++; if (bus.start_addr !== '0) begin failures++; $display("FAIL swtrig_start_addr got=%0d exp=0", bus.start_addr); end
    for (int a = 0; a < 8; a++) begin
      logic [DW-1:0] e;
      rd_mem(AW'(a), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL swtrig_ram[%0d] got=%0d exp=%0d", a, d, e); end
    end
    for (int a = 8; a < 10; a++) begin
      rd_mem(AW'(a), d);
      checks++; if (d === DW'(100 + a)) begin failures++; $display("FAIL swtrig_no_write[%0d] got=%0d exp=not %0d", a, d, 100 + a); end
    end
  endtask

  task automatic test_level();
    int lv[5] = '{-3, -1, 0, 5, 7};
    int prev;
    bit pv;
    bit trig;
    int cnt;
    int base;
    logic [DW-1:0] d;
    base = PRE ? 2 : 0;
    bus.capture_len = 11'd2;
    bus.trig_lvl    = '0;
    bus.trig_lvl_en = 1'b1;
    pulse_arm();
    pv = 1'b0; trig = 1'b0; cnt = 0; prev = 0;
    for (int i = 0; i < 5; i++) begin
      if (!trig && pv && prev < 0 && lv[i] >= 0) trig = 1'b1;
      if (trig && cnt < 2) begin exp_q.push_back(DW'(lv[i])); cnt++; end
      pv = 1'b1; prev = lv[i];
      strobe(DW'(lv[i]));
      if (i == 1) begin
        checks++; if (bus.dbg_state !== S_ARMED) begin failures++; $display("FAIL level_signed_no_trig got=%0d exp=%0d", bus.dbg_state, S_ARMED); end
      end
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL level_done got=%0b exp=1", bus.done); end
    checks++; if (bus.trig_addr !== AW'(base)) begin failures++; $display("FAIL level_trig_addr got=%0d exp=%0d", bus.trig_addr, base); end
    for (int a = 0; a < 2; a++) begin
      logic [DW-1:0] e;
      rd_mem(AW'(base + a), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL level_ram[%0d] got=%0h exp=%0h", base + a, d, e); end
    end
    pulse_arm();
    strobe(-16'sd5);
    pulse_arm();
    strobe(16'sd5);
    checks++; if (bus.dbg_state !== S_ARMED) begin failures++; $display("FAIL level_first_after_arm got=%0d exp=%0d", bus.dbg_state, S_ARMED); end
    strobe(16'sd6);
    strobe(-16'sd1);
    strobe(16'sd3);
    checks++; if (bus.dbg_state !== S_CAPTURE) begin failures++; $display("FAIL level_retrigger got=%0d exp=%0d", bus.dbg_state, S_CAPTURE); end
    bus.trig_lvl_en = 1'b0;
  endtask

  task automatic test_lengths();
    logic [DW-1:0] d;
    bus.capture_len = '0;
    pulse_arm();
    for (int i = 0; i < DEPTH; i++) begin
      pat[i] = DW'($urandom_range(0, 65535));
      exp_q.push_back(pat[i]);
      strobe(pat[i], i == 0);
      if (i == DEPTH - 2) begin
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL len0_done_early got=%0b exp=0", bus.done); end
      end
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL len0_done got=%0b exp=1", bus.done); end
    for (int a = 0; a < DEPTH; a++) begin
      logic [DW-1:0] e;
      rd_mem(AW'(a), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL len0_ram[%0d] got=%0h exp=%0h", a, d, e); end
    end
    bus.capture_len = 11'd1;
    pulse_arm();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL arm_clears_done got=%0b exp=0", bus.done); end
    strobe(16'h1234, 1'b1);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL len1_done got=%0b exp=1", bus.done); end
    checks++; if (bus.dbg_state !== S_DONE) begin failures++; $display("FAIL len1_state got=%0d exp=%0d", bus.dbg_state, S_DONE); end
    strobe(16'h4321);
    rd_mem(AW'(0), d);
    checks++; if (d !== 16'h1234) begin failures++; $display("FAIL len1_ram0 got=%0h exp=1234", d); end
    rd_mem(AW'(1), d);
    checks++; if (d !== pat[1]) begin failures++; $display("FAIL len1_ram1_kept got=%0h exp=%0h", d, pat[1]); end
  endtask

  task automatic test_conflicts();
    bus.capture_len = 11'd8;
    bus.arm = 1'b1;
    bus.sw_trig = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.sw_trig = 1'b0;
    checks++; if (bus.dbg_state !== S_ARMED) begin failures++; $display("FAIL arm_vs_trig_state got=%0d exp=%0d", bus.dbg_state, S_ARMED); end
    strobe(16'h1111);
    checks++; if (bus.dbg_state !== S_ARMED) begin failures++; $display("FAIL arm_drops_trig got=%0d exp=%0d", bus.dbg_state, S_ARMED); end
    strobe(16'h2222, 1'b1);
    strobe(16'h3333);
    checks++; if (bus.dbg_state !== S_CAPTURE) begin failures++; $display("FAIL conflict_capture got=%0d exp=%0d", bus.dbg_state, S_CAPTURE); end
    pulse_arm();
    checks++; if (bus.dbg_state !== S_ARMED) begin failures++; $display("FAIL rearm_state got=%0d exp=%0d", bus.dbg_state, S_ARMED); end
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL rearm_flags got=%0b%0b exp=10", bus.busy, bus.done); end
    exp_q.push_back(16'h7777);
    exp_q.push_back(16'h8888);
    strobe(16'h7777, 1'b1);
    strobe(16'h8888);
    checks++; if (bus.trig_addr !== '0) begin failures++; $display("FAIL rearm_trig_addr got=%0d exp=0", bus.trig_addr); end
  endtask

  task automatic test_reset_mid_capture();
    logic [DW-1:0] d;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", bus.done); end
    checks++; if (bus.start_addr !== '0) begin failures++; $display("FAIL midrst_start got=%0d exp=0", bus.start_addr); end
    checks++; if (bus.trig_addr !== '0) begin failures++; $display("FAIL midrst_trig got=%0d exp=0", bus.trig_addr); end
    checks++; if (bus.dbg_state !== S_IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
    for (int a = 0; a < 2; a++) begin
      logic [DW-1:0] e;
      rd_mem(AW'(a), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL rearm_ram[%0d] got=%0h exp=%0h", a, d, e); end
    end
  endtask

`ifdef DS_CAPTURE_PRETRIG_EN
  task automatic test_pretrig();
    logic [DW-1:0] d;
    bus.capture_len = 11'd6;
    bus.pretrig_len = 10'd3;
    pulse_arm();
    for (int i = 0; i < 10; i++) strobe(DW'(i));
    strobe(DW'(10), 1'b1);
    checks++; if (bus.trig_addr !== 10'd10) begin failures++; $display("FAIL pre_trig_addr got=%0d exp=10", bus.trig_addr); end
    checks++; if (bus.start_addr !== 10'd7) begin failures++; $display("FAIL pre_start_addr got=%0d exp=7", bus.start_addr); end
    strobe(DW'(11));
    strobe(DW'(12));
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL pre_done got=%0b exp=1", bus.done); end
    strobe(DW'(13));
    for (int v = 7; v <= 12; v++) exp_q.push_back(DW'(v));
    for (int a = 7; a <= 12; a++) begin
      logic [DW-1:0] e;
      rd_mem(AW'(a), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL pre_ram[%0d] got=%0d exp=%0d", a, d, e); end
    end
    rd_mem(AW'(13), d);
    checks++; if (d === DW'(13)) begin failures++; $display("FAIL pre_no_write got=%0d exp=not 13", d); end
    bus.pretrig_len = '0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.sample_in = '0; bus.sample_ce = 1'b0; bus.arm = 1'b0; bus.sw_trig = 1'b0;
    bus.trig_lvl_en = 1'b0; bus.trig_lvl = '0; bus.capture_len = '0;
    bus.pretrig_len = '0; bus.rd_addr = '0;
    test_reset();
    test_sw_trig();
    test_level();
    test_lengths();
    test_conflicts();
    test_reset_mid_capture();
`ifdef DS_CAPTURE_PRETRIG_EN
    test_pretrig();
`endif
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
